dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 216 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder; define DMEM_SPLIT_EN for two-beat word-crossing accesses
module dmem_responder #(
  parameter int DEPTH_WORDS = 512
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_wren,
  input  logic        i_req_signed,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BYTE_SPAN = 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
`ifdef DMEM_SPLIT_EN
    S_BEAT1 = 2'd2,
`endif
    S_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // captured request
  logic [1:0]    q_off;
  logic [AW-1:0] q_word;
  logic [31:0]   q_wdata;
  logic [1:0]    q_size;
  logic          q_wren;
  logic          q_signed;
  logic          q_err;
`ifdef DMEM_SPLIT_EN
  logic          q_cross;
`endif

  // request decode on the live inputs
  logic [2:0]  req_bytes;
  logic [32:0] req_last;
  logic        req_cross;
  logic        req_err;
  logic        accept;

  // RAM port
  logic [31:0]   mem [DEPTH_WORDS];
  logic          ram_en;
  logic [AW-1:0] ram_idx;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wd;
  logic [31:0]   rd_lo;
`ifdef DMEM_SPLIT_EN
  logic [31:0]   rd_hi;
  logic [7:0]    be_wide;
  logic [63:0]   wd_wide;
`else
  logic [3:0]    be_lo;
  logic [31:0]   wd_lo;
`endif

  logic [3:0]  size_mask;
  logic [31:0] rd_raw;
  logic [31:0] rd_ext;

  // footprint and error classification; the 33-bit sum catches the wrap at the top of the address space
  always_comb begin
    case (i_req_size)
      2'b00:   req_bytes = 3'd1;
      2'b01:   req_bytes = 3'd2;
      default: req_bytes = 3'd4;
    endcase
    req_last  = {1'b0, i_req_addr} + {30'd0, req_bytes} - 33'd1;
    req_cross = (req_last[31:2] != i_req_addr[31:2]);
`ifdef DMEM_SPLIT_EN
    req_err   = (req_last >= BYTE_SPAN);
`else
    req_err   = (req_last >= BYTE_SPAN) || req_cross;
`endif
  end

  assign accept = i_req_valid && (state_q == S_IDLE);

  // capture every request field on the accept edge so the requester may move on
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      q_off    <= '0;
      q_word   <= '0;
      q_wdata  <= '0;
      q_size   <= '0;
      q_wren   <= 1'b0;
      q_signed <= 1'b0;
      q_err    <= 1'b0;
`ifdef DMEM_SPLIT_EN
      q_cross  <= 1'b0;
`endif
    end else if (accept) begin
      q_off    <= i_req_addr[1:0];
      q_word   <= i_req_addr[AW+1:2];
      q_wdata  <= i_req_wdata;
      q_size   <= i_req_size;
      q_wren   <= i_req_wren;
      q_signed <= i_req_signed;
      q_err    <= req_err;
`ifdef DMEM_SPLIT_EN
      q_cross  <= req_cross;
`endif
    end
  end

  // lane alignment: a two-word window holds the BEAT0 lanes low and the BEAT1 lanes high
  always_comb begin
    case (q_size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
`ifdef DMEM_SPLIT_EN
    be_wide = {4'b0000, size_mask} << q_off;
    wd_wide = {32'd0, q_wdata} << {q_off, 3'b000};
`else
    be_lo   = size_mask << q_off;
    wd_lo   = q_wdata << {q_off, 3'b000};
`endif
  end

  // state register; reset aborts any access in flight
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // next state, RAM beat control and response outputs
  always_comb begin
    state_d     = state_q;
    ram_en      = 1'b0;
    ram_idx     = q_word;
`ifdef DMEM_SPLIT_EN
    ram_be      = be_wide[3:0];
    ram_wd      = wd_wide[31:0];
`else
    ram_be      = be_lo;
    ram_wd      = wd_lo;
`endif
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_err   = 1'b0;
    o_rsp_rdata = 32'd0;
    case (state_q)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_d = S_BEAT0;
      end
      S_BEAT0: begin
        ram_en = !q_err;
`ifdef DMEM_SPLIT_EN
        state_d = (q_cross && !q_err) ? S_BEAT1 : S_RESP;
`else
        state_d = S_RESP;
`endif
      end
`ifdef DMEM_SPLIT_EN
      S_BEAT1: begin
        ram_en  = 1'b1;
        ram_idx = q_word + AW'(1);
        ram_be  = be_wide[7:4];
        ram_wd  = wd_wide[63:32];
        state_d = S_RESP;
      end
`endif
      S_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = q_err;
        o_rsp_rdata = (q_err || q_wren) ? 32'd0 : rd_ext;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // word RAM: byte-masked write, synchronous read registered per beat; contents survive reset
  always_ff @(posedge i_clk) begin
    if (ram_en && q_wren) begin
      for (int l = 0; l < 4; l++) begin
        if (ram_be[l]) mem[ram_idx][l*8 +: 8] <= ram_wd[l*8 +: 8];
      end
    end
    if (ram_en && !q_wren && (state_q == S_BEAT0)) rd_lo <= mem[ram_idx];
`ifdef DMEM_SPLIT_EN
    if (ram_en && !q_wren && (state_q == S_BEAT1)) rd_hi <= mem[ram_idx];
`endif
  end

  // merge the beat words down to a right-aligned result and extend it
  always_comb begin
`ifdef DMEM_SPLIT_EN
    rd_raw = 32'({rd_hi, rd_lo} >> {q_off, 3'b000});
`else
    rd_raw = rd_lo >> {q_off, 3'b000};
`endif
    case (q_size)
      2'b00:   rd_ext = q_signed ? {{24{rd_raw[7]}}, rd_raw[7:0]}
                                 : {24'd0, rd_raw[7:0]};
      2'b01:   rd_ext = q_signed ? {{16{rd_raw[15]}}, rd_raw[15:0]}
                                 : {16'd0, rd_raw[15:0]};
      default: rd_ext = rd_raw;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (covers DMEM_SPLIT_EN on and off)
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_wren;
  logic        req_signed;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          rsp_edge;
  } exp_t;

  exp_t sbq[$];

  dmem_responder #(.DEPTH_WORDS(512)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .i_req_size   (req_size),
    .i_req_wren   (req_wren),
    .i_req_signed (req_signed),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // monitor: every response pulse is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=valid rdata=%h err=%0d expected=no_response", rsp_rdata, rsp_err);
      end else begin
        e = sbq.pop_front();
        chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
        chk({e.name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        chk({e.name, "_edge"}, cyc + 1, e.rsp_edge);
      end
    end
  end

  // issue one request, record the expected response, and check ready drops for the whole access
  task automatic do_req(input string nm, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic wr, input logic sg,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    req_addr   = a;
    req_wdata  = wd;
    req_size   = sz;
    req_wren   = wr;
    req_signed = sg;
    req_valid  = 1'b1;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk({nm, "_accept_timeout"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = 32'hXXXX_XXXX;
    req_wdata  = 32'hXXXX_XXXX;
    e.name     = nm;
    e.rdata    = exp_rd;
    e.err      = exp_err;
    e.rsp_edge = cyc + lat;
    sbq.push_back(e);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk({nm, "_busy"}, {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk);
    chk({nm, "_ready_again"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_size   = 2'd0;
    req_wren   = 1'b0;
    req_signed = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_err",   {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;

    // aligned word store/load and extension
    do_req("st_w010",  32'h010, 32'hDEADBEEF, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 2);
    do_req("ld_w010",  32'h010, 32'h0, 2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 2);
    do_req("ld_bs013", 32'h013, 32'h0, 2'b00, 1'b0, 1'b1, 32'hFFFFFFDE, 1'b0, 2);
    do_req("ld_bu013", 32'h013, 32'h0, 2'b00, 1'b0, 1'b0, 32'h000000DE, 1'b0, 2);
    do_req("ld_hs011", 32'h011, 32'h0, 2'b01, 1'b0, 1'b1, 32'hFFFFADBE, 1'b0, 2);
    do_req("ld_hu012", 32'h012, 32'h0, 2'b01, 1'b0, 1'b0, 32'h0000DEAD, 1'b0, 2);
    do_req("ld_bs010", 32'h010, 32'h0, 2'b00, 1'b0, 1'b1, 32'hFFFFFFEF, 1'b0, 2);
    do_req("ld_ws010", 32'h010, 32'h0, 2'b11, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 2);

    // partial stores preserve unmasked lanes
    do_req("st_b012",  32'h012, 32'hFFFFFF55, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2);
    do_req("st_h010",  32'h010, 32'hFFFF1234, 2'b01, 1'b1, 1'b0, 32'h0, 1'b0, 2);
    do_req("ld_mix",   32'h010, 32'h0, 2'b10, 1'b0, 1'b0, 32'hDE551234, 1'b0, 2);

    // range errors
    do_req("st_w7fc",  32'h7FC, 32'hCAFEF00D, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 2);
    do_req("ld_w7fe",  32'h7FE, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0, 1'b1, 2);
    do_req("st_b800",  32'h800, 32'h000000AA, 2'b00, 1'b1, 1'b0, 32'h0, 1'b1, 2);
    do_req("ld_wrap",  32'hFFFFFFFE, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0, 1'b1, 2);
    do_req("ld_7fc",   32'h7FC, 32'h0, 2'b10, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 2);
    do_req("ld_b7ff",  32'h7FF, 32'h0, 2'b00, 1'b0, 1'b0, 32'h000000CA, 1'b0, 2);

    // prefills for the crossing and reset tests
    do_req("pf_014",   32'h014, 32'h01020304, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 2);
    do_req("pf_020",   32'h020, 32'h00000000, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 2);
    do_req("pf_024",   32'h024, 32'h00000000, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 2);
    do_req("pf_030",   32'h030, 32'h00000000, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 2);
    do_req("pf_034",   32'h034, 32'hA5A5A5A5, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 2);

`ifdef DMEM_SPLIT_EN
    do_req("st_x022",  32'h022, 32'h11223344, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 3);
    do_req("ld_w020",  32'h020, 32'h0, 2'b10, 1'b0, 1'b0, 32'h33440000, 1'b0, 2);
    do_req("ld_w024",  32'h024, 32'h0, 2'b10, 1'b0, 1'b0, 32'h00001122, 1'b0, 2);
    do_req("ld_x022",  32'h022, 32'h0, 2'b10, 1'b0, 1'b0, 32'h11223344, 1'b0, 3);
    do_req("ld_xh023", 32'h023, 32'h0, 2'b01, 1'b0, 1'b1, 32'h00002233, 1'b0, 3);

    // reset during BEAT1 of a crossing store
    @(negedge clk);
    chk("rst_pre_ready", {31'd0, req_ready}, 32'd1);
    req_addr   = 32'h031;
    req_wdata  = 32'h11223344;
    req_size   = 2'b10;
    req_wren   = 1'b1;
    req_signed = 1'b0;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_ready_async", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("rst_no_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready_after", {31'd0, req_ready}, 32'd1);
    do_req("ld_rst030", 32'h030, 32'h0, 2'b10, 1'b0, 1'b0, 32'h22334400, 1'b0, 2);
    do_req("ld_rst034", 32'h034, 32'h0, 2'b10, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 2);
`else
    do_req("st_xh013", 32'h013, 32'h0000AAAA, 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2);
    do_req("ld_k010",  32'h010, 32'h0, 2'b10, 1'b0, 1'b0, 32'hDE551234, 1'b0, 2);
    do_req("ld_k014",  32'h014, 32'h0, 2'b10, 1'b0, 1'b0, 32'h01020304, 1'b0, 2);
    do_req("ld_x022",  32'h022, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0, 1'b1, 2);

    // reset during BEAT0 of a word store: nothing is written
    @(negedge clk);
    chk("rst_pre_ready", {31'd0, req_ready}, 32'd1);
    req_addr   = 32'h030;
    req_wdata  = 32'h0BADF00D;
    req_size   = 2'b10;
    req_wren   = 1'b1;
    req_signed = 1'b0;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ready_async", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("rst_no_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready_after", {31'd0, req_ready}, 32'd1);
    do_req("ld_rst030", 32'h030, 32'h0, 2'b10, 1'b0, 1'b0, 32'h00000000, 1'b0, 2);
    do_req("ld_rst034", 32'h034, 32'h0, 2'b10, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 2);
`endif

    repeat (5) @(negedge clk);
    chk("sb_drain", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
